// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage memory responder.
// Local word-addressed data RAM with byte-lane writes and a registered read
// port, plus an MMIO window forwarded to a peripheral over req/ack. The
// pipeline is stalled through mem_hold while an MMIO access is outstanding.
module data_mem_responder #(
  parameter int          WORDS_LOG2 = 10,
  parameter logic [31:0] MMIO_BASE  = 32'haaaaa000,
  parameter int          TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        mem_wea,
  input  logic        mem_rea,
  input  logic [3:0]  mem_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        mem_hold,
  output logic        mmio_req,
  output logic        mmio_we,
  output logic [11:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  output logic [3:0]  mmio_be,
  input  logic        mmio_ack,
  input  logic [31:0] mmio_rdata,
  output logic        mmio_err
);

  // Last counter value of the REQ wait; REQ lasts TIMEOUT cycles at most.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [7:0]              cnt;
  logic [31:0]             ram [2**WORDS_LOG2];
  logic [WORDS_LOG2-1:0]   ram_idx;
  logic [31:0]             wdata;
  logic                    mmio_hit;
  logic                    access;
  logic                    ram_we;
  logic                    ram_re;

  // Store data arrives with the byte/half in the low bits; move it onto the
  // byte lanes selected by the low address bits (rotate left by 8*offset).
  function automatic logic [31:0] lane_align(input logic [31:0] din,
                                             input logic [1:0]  off);
    logic [31:0] r;
    case (off)
      2'd0:    r = din;
      2'd1:    r = {din[23:0], din[31:24]};
      2'd2:    r = {din[15:0], din[31:16]};
      default: r = {din[7:0],  din[31:8]};
    endcase
    return r;
  endfunction

  assign wdata    = lane_align(mem_din, mem_addr[1:0]);
  assign ram_idx  = mem_addr[WORDS_LOG2+1:2];
  assign mmio_hit = (mem_addr[31:12] == MMIO_BASE[31:12]);
  assign access   = mem_wea | mem_rea;

  // RAM is only touched from IDLE; REQ/DONE present a held MMIO request.
  assign ram_we = (state == IDLE) && !mmio_hit && mem_wea;
  assign ram_re = (state == IDLE) && !mmio_hit && mem_rea && !mem_wea;

  // The stall starts combinationally in the cycle the MMIO hit is seen and is
  // forced low while reset is asserted.
  assign mem_hold = Rst && (((state == IDLE) && mmio_hit && access) ||
                            (state == REQ));
  assign mmio_req   = (state == REQ);
  assign mmio_we    = mem_wea;
  assign mmio_addr  = mem_addr[11:0];
  assign mmio_wdata = wdata;
  assign mmio_be    = mem_en;

  // Local RAM write port: per-lane byte enables, contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_en[i]) ram[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Control FSM: RAM read register, MMIO handshake, timeout and error flag.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      mem_dout <= 32'd0;
      mmio_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mmio_hit && access) begin
            state <= REQ;
            cnt   <= 8'd0;
          end else if (ram_re) begin
            mem_dout <= ram[ram_idx];
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          // An ack in the final wait cycle still counts as a completion.
          if (mmio_ack) begin
            if (!mem_wea) mem_dout <= mmio_rdata;
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            mmio_err <= 1'b1;
            if (!mem_wea) mem_dout <= 32'hDEADBEEF;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenarios followed by random
// RAM and MMIO traffic, checked against a transaction-level memory model.
module tb_data_mem_responder;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        Rst;
  logic        mem_wea, mem_rea;
  logic [3:0]  mem_en;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_hold, mmio_req, mmio_we, mmio_ack, mmio_err;
  logic [11:0] mmio_addr;
  logic [31:0] mmio_wdata, mmio_rdata;
  logic [3:0]  mmio_be;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the 16 RAM words in use, the read register and the flag.
  logic [31:0] mdl [16];
  logic [31:0] mdl_dout;
  logic        mdl_err;

  data_mem_responder dut (
    .clk(clk), .Rst(Rst),
    .mem_wea(mem_wea), .mem_rea(mem_rea), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_hold(mem_hold), .mmio_req(mmio_req), .mmio_we(mmio_we),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_be(mmio_be),
    .mmio_ack(mmio_ack), .mmio_rdata(mmio_rdata), .mmio_err(mmio_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Lane i of the written word carries byte ((i - offset) mod 4) of din.
  function automatic logic [31:0] exp_lanes(input logic [31:0] din,
                                            input logic [1:0] off);
    logic [31:0] r;
    int o, src;
    o = int'(off);
    for (int i = 0; i < 4; i++) begin
      src = (i - o + 4) % 4;
      r[8*i +: 8] = din[8*src +: 8];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One non-MMIO access; addresses keep bits [11:6] zero so word = addr[5:2].
  task automatic ram_op(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] din, input logic [3:0] en,
                        input logic stray_ack);
    logic [31:0] lanes;
    int idx;
    mem_wea = we; mem_rea = re; mem_addr = addr; mem_din = din; mem_en = en;
    mmio_ack = stray_ack; mmio_rdata = $urandom;
    #1;
    chk("ram_hold", 32'(mem_hold), 32'd0);
    step();
    mmio_ack = 1'b0;
    idx = int'(addr[5:2]);
    lanes = exp_lanes(din, addr[1:0]);
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (en[i]) mdl[idx][8*i +: 8] = lanes[8*i +: 8];
    end else if (re) begin
      mdl_dout = mdl[idx];
    end
    chk("ram_dout", mem_dout, mdl_dout);
    chk("ram_req", 32'(mmio_req), 32'd0);
  endtask

  // One MMIO access; the peripheral acks in REQ cycle ack_at (0 = never).
  task automatic mmio_op(input logic we, input logic [31:0] addr,
                         input logic [31:0] din, input logic [3:0] en,
                         input int ack_at, input logic [31:0] rdata);
    int hold_n, req_n, exp_req;
    bit done, seen;
    hold_n = 0; req_n = 0; done = 0; seen = 0;
    mem_wea = we; mem_rea = !we; mem_addr = addr; mem_din = din; mem_en = en;
    mmio_ack = 1'b0;
    for (int c = 0; c < TIMEOUT + 10; c++) begin
      #1;
      if (mem_hold) hold_n++;
      if (mmio_req) begin
        req_n++;
        if (!seen) begin
          seen = 1;
          chk("mmio_we", 32'(mmio_we), 32'(we));
          chk("mmio_addr", 32'(mmio_addr), 32'(addr[11:0]));
          chk("mmio_be", 32'(mmio_be), 32'(en));
          if (we) chk("mmio_wdata", mmio_wdata, exp_lanes(din, addr[1:0]));
        end
        if (req_n == ack_at) begin
          mmio_ack = 1'b1;
          mmio_rdata = rdata;
        end
      end else if (!mem_hold) begin
        done = 1;
        break;
      end
      step();
      mmio_ack = 1'b0;
      mmio_rdata = $urandom;
    end
    chk("mmio_done", 32'(done), 32'd1);
    if (ack_at >= 1 && ack_at <= TIMEOUT) begin
      exp_req = ack_at;
      if (!we) mdl_dout = rdata;
    end else begin
      exp_req = TIMEOUT;
      mdl_err = 1'b1;
      if (!we) mdl_dout = 32'hDEADBEEF;
    end
    chk("mmio_req_cycles", 32'(req_n), 32'(exp_req));
    chk("mmio_hold_cycles", 32'(hold_n), 32'(exp_req + 1));
    chk("mmio_dout", mem_dout, mdl_dout);
    chk("mmio_err", 32'(mmio_err), 32'(mdl_err));
    // DONE still presents the request; it must not restart or change dout.
    step();
    chk("mmio_after_done", mem_dout, mdl_dout);
    mem_wea = 1'b0; mem_rea = 1'b0;
    #1;
    chk("mmio_idle_hold", 32'(mem_hold), 32'd0);
  endtask

  function automatic logic [31:0] ram_addr(input int word, input logic [1:0] off);
    logic [31:0] a;
    a = $urandom;
    a[11:0] = {6'd0, 4'(word), off};
    if (a[31:12] == 20'haaaaa) a[31] = 1'b0;
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d, a;
    logic [1:0]  off;
    logic [3:0]  en;
    int          sz, kind, ack_at;

    Rst = 1'b0; mem_wea = 0; mem_rea = 0; mem_en = 4'hF; mem_addr = 0;
    mem_din = 0; mmio_ack = 0; mmio_rdata = 0;
    mdl_dout = 32'd0; mdl_err = 1'b0;
    #12;
    chk("rst_dout", mem_dout, 32'd0);
    chk("rst_hold", 32'(mem_hold), 32'd0);
    chk("rst_req", 32'(mmio_req), 32'd0);
    chk("rst_err", 32'(mmio_err), 32'd0);
    step();
    Rst = 1'b1;
    step();

    for (int w = 0; w < 16; w++) ram_op(1, 0, ram_addr(w, 2'd0), $urandom, 4'hF, 0);

    // Word store then load.
    ram_op(1, 0, 32'h10, 32'h11223344, 4'hF, 0);
    ram_op(0, 1, 32'h10, 32'h0, 4'hF, 0);
    chk("sw_lw_const", mem_dout, 32'h11223344);

    // Byte and wrapping half stores into one word.
    ram_op(1, 0, 32'h20, 32'h0, 4'hF, 0);
    ram_op(1, 0, 32'h21, 32'h000000AB, 4'b0010, 0);
    ram_op(1, 0, 32'h23, 32'h0000CDEF, 4'b1001, 0);
    ram_op(0, 1, 32'h20, 32'h0, 4'hF, 0);
    chk("sb_sh_const", mem_dout, 32'hEF00ABCD);

    // MMIO read acked in the 4th REQ cycle.
    mmio_op(0, 32'haaaaa008, 32'h0, 4'hF, 4, 32'h5A);
    chk("mmio_rd_const", mem_dout, 32'h5A);

    // Ack coinciding with the last timeout cycle wins.
    mmio_op(0, 32'haaaaa00C, 32'h0, 4'hF, TIMEOUT, 32'h0BADF00D);
    chk("ack_wins_err", 32'(mmio_err), 32'd0);

    // MMIO write with no ack: timeout, sticky error, aliased RAM untouched.
    mmio_op(1, 32'haaaaa004, 32'h1, 4'hF, 0, 32'h0);
    chk("timeout_err_const", 32'(mmio_err), 32'd1);
    ram_op(0, 1, 32'h4, 32'h0, 4'hF, 0);

    // Simultaneous store and load: write happens, dout unchanged.
    ram_op(1, 1, 32'h30, 32'hFFFFFFFF, 4'hF, 0);
    ram_op(0, 1, 32'h30, 32'h0, 4'hF, 0);
    chk("wr_rd_const", mem_dout, 32'hFFFFFFFF);

    // Reset in the middle of REQ.
    mem_wea = 0; mem_rea = 1; mem_addr = 32'haaaaa010; mem_en = 4'hF;
    step(); step(); step();
    #2;
    Rst = 1'b0;
    #1;
    chk("midrst_req", 32'(mmio_req), 32'd0);
    chk("midrst_hold", 32'(mem_hold), 32'd0);
    chk("midrst_dout", mem_dout, 32'd0);
    chk("midrst_err", 32'(mmio_err), 32'd0);
    mdl_dout = 32'd0; mdl_err = 1'b0;
    step();
    mem_rea = 0; mmio_ack = 1'b1; mmio_rdata = 32'h12345678;
    step();
    mmio_ack = 1'b0;
    Rst = 1'b1;
    step();
    ram_op(0, 0, 32'h0, 32'h0, 4'hF, 1);
    chk("late_ack_dout", mem_dout, 32'd0);
    ram_op(0, 1, 32'h10, 32'h0, 4'hF, 0);
    chk("post_rst_ram", mem_dout, 32'h11223344);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      d    = $urandom;
      if (kind < 4) begin
        sz = $urandom_range(0, 2);
        off = (sz == 2) ? 2'd0 : 2'($urandom_range(0, 3));
        en = (sz == 0) ? 4'b0001 : (sz == 1) ? 4'b0011 : 4'b1111;
        en = 4'((8'({en, en}) << off) >> 4);
        ram_op(1, ($urandom_range(0, 4) == 0), ram_addr($urandom_range(0, 15), off),
               d, en, 1'($urandom_range(0, 1)));
      end else if (kind < 7) begin
        ram_op(0, 1, ram_addr($urandom_range(0, 15), 2'($urandom_range(0, 3))),
               d, 4'hF, 1'($urandom_range(0, 1)));
      end else if (kind < 8) begin
        ram_op(0, 0, ram_addr($urandom_range(0, 15), 2'd0), d, 4'hF,
               1'($urandom_range(0, 1)));
      end else begin
        a = {20'haaaaa, 12'($urandom)};
        ack_at = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 6);
        en = 4'($urandom_range(1, 15));
        mmio_op(1'($urandom_range(0, 1)), a, d, en, ack_at, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
